// File: rtl/nios_system2_processor2_cpu_mul_combine.sv
// nios_system2_processor2_cpu_mul_combine
//
// Combines the four registered 16x16 partial products of the CPU multiplier
// cell into the 32-bit result of mul / mulxss / mulxsu / mulxuu. The cell
// output is in the M stage. It travels through the A stage and the W stage.
//
//   p1 = lo(src1) * lo(src2)   always unsigned
//   p2 = lo(src1) * hi(src2)   signed when src2 is signed
//   p3 = hi(src1) * lo(src2)   signed when src1 is signed
//   p4 = hi(src1) * hi(src2)   signed when either source is signed
//
//   product = {p4, p1} + (sext(p2 + p3) << 16)   (mod 2^64)
//
// Parameters
//   REGISTER_OUTPUT  1: the selected word is registered into the W stage
//                    0: the W outputs are driven combinationally from stage A
//
// Ports
//   clk                     rising-edge clock
//   reset_n                 asynchronous active-low reset
//   A_en                    pipeline advance; 0 holds every stage
//   A_pipe_flush            kills every in-flight multiply (overrides A_en)
//   M_valid_mul             a multiply is present in the M stage
//   M_ctrl_mul_hi           1 selects product[63:32], 0 selects product[31:0]
//   M_ctrl_mul_src1_signed  signedness of source operand 1
//   M_ctrl_mul_src2_signed  signedness of source operand 2
//   M_mul_cell_p1..p4       partial products (see above)
//   W_mul_result            selected result word
//   W_mul_valid             W_mul_result holds a completed multiply

module nios_system2_processor2_cpu_mul_combine #(
    parameter int REGISTER_OUTPUT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        A_en,
    input  logic        A_pipe_flush,
    input  logic        M_valid_mul,
    input  logic        M_ctrl_mul_hi,
    input  logic        M_ctrl_mul_src1_signed,
    input  logic        M_ctrl_mul_src2_signed,
    input  logic [31:0] M_mul_cell_p1,
    input  logic [31:0] M_mul_cell_p2,
    input  logic [31:0] M_mul_cell_p3,
    input  logic [31:0] M_mul_cell_p4,
    output logic [31:0] W_mul_result,
    output logic        W_mul_valid
);

    // The two cross terms are widened to 34 bits so their sum cannot overflow.
    logic        m_p2_ext;
    logic        m_p3_ext;
    logic [33:0] m_mid;

    assign m_p2_ext = M_mul_cell_p2[31] & M_ctrl_mul_src2_signed;
    assign m_p3_ext = M_mul_cell_p3[31] & M_ctrl_mul_src1_signed;
    assign m_mid    = {{2{m_p2_ext}}, M_mul_cell_p2} + {{2{m_p3_ext}}, M_mul_cell_p3};

    // Stage A. The signedness of p4 is not carried forward: within 64 bits
    // the concatenation {p4, p1} is identical whether p4 is signed or not,
    // so it has no effect on either result word.
    logic [31:0] a_p1;
    logic [31:0] a_p4;
    logic [33:0] a_mid;
    logic        a_mul_hi;
    logic        a_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_p1     <= '0;
            a_p4     <= '0;
            a_mid    <= '0;
            a_mul_hi <= 1'b0;
        end else if (A_en) begin
            a_p1     <= M_mul_cell_p1;
            a_p4     <= M_mul_cell_p4;
            a_mid    <= m_mid;
            a_mul_hi <= M_ctrl_mul_hi;
        end
    end

    // Valid bits follow the data but a flush wins over A_en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_valid <= 1'b0;
        end else if (A_pipe_flush) begin
            a_valid <= 1'b0;
        end else if (A_en) begin
            a_valid <= M_valid_mul;
        end
    end

    logic [63:0] a_product;
    logic [31:0] a_sel_result;

    assign a_product    = {a_p4, a_p1} + ({{30{a_mid[33]}}, a_mid} << 16);
    assign a_sel_result = a_mul_hi ? a_product[63:32] : a_product[31:0];

    generate
        if (REGISTER_OUTPUT != 0) begin : g_reg_out
            logic [31:0] w_result;
            logic        w_valid;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    w_result <= '0;
                end else if (A_en) begin
                    w_result <= a_sel_result;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    w_valid <= 1'b0;
                end else if (A_pipe_flush) begin
                    w_valid <= 1'b0;
                end else if (A_en) begin
                    w_valid <= a_valid;
                end
            end

            assign W_mul_result = w_result;
            assign W_mul_valid  = w_valid;
        end else begin : g_comb_out
            assign W_mul_result = a_sel_result;
            assign W_mul_valid  = a_valid;
        end
    endgenerate

endmodule

// File: tb/tb_nios_system2_processor2_cpu_mul_combine.sv
// Bench for nios_system2_processor2_cpu_mul_combine (REGISTER_OUTPUT = 1).
// The reference model works on whole 32-bit operands: it forms the full
// 64-bit product by plain multiplication and moves expected words through a
// two-slot pipeline that obeys A_en / flush / reset. Partial products fed to
// the DUT are derived from the same operands, the way the multiplier cell would.

module tb_nios_system2_processor2_cpu_mul_combine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        A_en;
    logic        A_pipe_flush;
    logic        M_valid_mul;
    logic        M_ctrl_mul_hi;
    logic        M_ctrl_mul_src1_signed;
    logic        M_ctrl_mul_src2_signed;
    logic [31:0] M_mul_cell_p1;
    logic [31:0] M_mul_cell_p2;
    logic [31:0] M_mul_cell_p3;
    logic [31:0] M_mul_cell_p4;
    logic [31:0] W_mul_result;
    logic        W_mul_valid;

    logic [31:0] op_a;
    logic [31:0] op_b;

    int n_cmp = 0;
    int n_bad = 0;
    int n_results = 0;

    nios_system2_processor2_cpu_mul_combine #(.REGISTER_OUTPUT(1)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .A_en                   (A_en),
        .A_pipe_flush           (A_pipe_flush),
        .M_valid_mul            (M_valid_mul),
        .M_ctrl_mul_hi          (M_ctrl_mul_hi),
        .M_ctrl_mul_src1_signed (M_ctrl_mul_src1_signed),
        .M_ctrl_mul_src2_signed (M_ctrl_mul_src2_signed),
        .M_mul_cell_p1          (M_mul_cell_p1),
        .M_mul_cell_p2          (M_mul_cell_p2),
        .M_mul_cell_p3          (M_mul_cell_p3),
        .M_mul_cell_p4          (M_mul_cell_p4),
        .W_mul_result           (W_mul_result),
        .W_mul_valid            (W_mul_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ext64(input logic [31:0] x, input logic s);
        return s ? {{32{x[31]}}, x} : {32'b0, x};
    endfunction

    // Expected result word straight from the full-width product.
    function automatic logic [31:0] full_mul(input logic [31:0] a, input logic [31:0] b,
                                             input logic sa, input logic sb, input logic hi);
        logic [63:0] prod;
        prod = ext64(a, sa) * ext64(b, sb);
        return hi ? prod[63:32] : prod[31:0];
    endfunction

    // One 16x16 partial product, as the multiplier cell would produce it.
    function automatic logic [31:0] pp(input logic [15:0] x, input logic xs,
                                       input logic [15:0] y, input logic ys);
        logic [63:0] xv;
        logic [63:0] yv;
        logic [63:0] p;
        xv = xs ? {{48{x[15]}}, x} : {48'b0, x};
        yv = ys ? {{48{y[15]}}, y} : {48'b0, y};
        p  = xv * yv;
        return p[31:0];
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic sa, input logic sb, input logic hi, input logic v);
        op_a = a;
        op_b = b;
        M_ctrl_mul_src1_signed = sa;
        M_ctrl_mul_src2_signed = sb;
        M_ctrl_mul_hi = hi;
        M_valid_mul = v;
        M_mul_cell_p1 = pp(a[15:0],  1'b0, b[15:0],  1'b0);
        M_mul_cell_p2 = pp(a[15:0],  1'b0, b[31:16], sb);
        M_mul_cell_p3 = pp(a[31:16], sa,   b[15:0],  1'b0);
        M_mul_cell_p4 = pp(a[31:16], sa,   b[31:16], sb);
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reference pipeline: slot A and slot W, each an expected word plus valid.
    logic        ma_v, mw_v;
    logic [31:0] ma_r, mw_r;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ma_v <= 1'b0;
            mw_v <= 1'b0;
            ma_r <= '0;
            mw_r <= '0;
        end else if (A_en) begin
            mw_r <= ma_r;
            mw_v <= ma_v & ~A_pipe_flush;
            ma_r <= full_mul(op_a, op_b, M_ctrl_mul_src1_signed, M_ctrl_mul_src2_signed, M_ctrl_mul_hi);
            ma_v <= M_valid_mul & ~A_pipe_flush;
        end else if (A_pipe_flush) begin
            ma_v <= 1'b0;
            mw_v <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison, sampled 2 time units after the edge.
    always @(posedge clk) begin
        #2;
        if (reset_n) begin
            chk("w_valid", {31'b0, W_mul_valid}, {31'b0, mw_v});
            if (mw_v) chk("w_result", W_mul_result, mw_r);
            if (W_mul_valid) n_results++;
        end
    end

    // Single multiply, checked against a hand-computed literal two edges later.
    task automatic lit(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb, input logic hi, input logic [31:0] exp);
        @(negedge clk);
        A_en = 1'b1;
        drive(a, b, sa, sb, hi, 1'b1);
        @(negedge clk);
        idle();
        @(posedge clk);
        #2;
        chk({name, "_valid"}, {31'b0, W_mul_valid}, 32'd1);
        chk(name, W_mul_result, exp);
    endtask

    initial begin : stim
        int          cnt0;
        logic [31:0] held;

        reset_n = 1'b0;
        A_en = 1'b0;
        A_pipe_flush = 1'b0;
        idle();
        #1;
        chk("reset_valid", {31'b0, W_mul_valid}, 32'd0);
        chk("reset_result", W_mul_result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        lit("u_lo_3x5",      32'd3,        32'd5,        1'b0, 1'b0, 1'b0, 32'h0000000F);
        lit("uu_hi_ff",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE);
        lit("ss_hi_ff",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00000000);
        lit("ss_lo_ff",      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h00000001);
        lit("ss_hi_8000",    32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000);
        lit("su_hi_m2x3",    32'hFFFFFFFE, 32'd3,        1'b1, 1'b0, 1'b1, 32'hFFFFFFFF);
        lit("su_lo_m2x3",    32'hFFFFFFFE, 32'd3,        1'b1, 1'b0, 1'b0, 32'hFFFFFFFA);
        lit("us_lo_3xm2",    32'd3,        32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFA);
        lit("uu_hi_10000sq", 32'h00010000, 32'h00010000, 1'b0, 1'b0, 1'b1, 32'h00000001);

        // Stall: one edge into stage A, five held cycles, then the second edge.
        @(negedge clk);
        A_en = 1'b1;
        drive(32'd1000, 32'd1000, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        A_en = 1'b0;
        idle();
        held = W_mul_result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, W_mul_valid}, 32'd0);
            chk("stall_hold", W_mul_result, held);
        end
        A_en = 1'b1;
        @(posedge clk);
        #2;
        chk("stall_done_valid", {31'b0, W_mul_valid}, 32'd1);
        chk("stall_done", W_mul_result, 32'h000F4240);

        // Back-to-back: four results on four consecutive cycles.
        cnt0 = n_results;
        @(negedge clk); drive(32'hFFFFFFF9, 32'd9,        1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk); drive(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk); drive(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk); drive(32'h7FFFFFFF, 32'h80000001, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk); idle();
        @(posedge clk);
        #2;
        chk("b2b_count", n_results - cnt0, 32'd4);
        repeat (3) @(negedge clk);
        chk("b2b_drained", n_results - cnt0, 32'd4);

        // Flush with A_en=0 while the op sits in stage A.
        cnt0 = n_results;
        @(negedge clk); drive(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); idle(); A_en = 1'b0; A_pipe_flush = 1'b1;
        @(negedge clk); A_pipe_flush = 1'b0; A_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("flush_stall_none", n_results - cnt0, 32'd0);

        // Flush with A_en=1 while one op is in A and one in W.
        cnt0 = n_results;
        @(negedge clk); drive(32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); drive(32'd8, 32'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); idle(); A_pipe_flush = 1'b1;
        @(negedge clk); A_pipe_flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush_run_count", n_results - cnt0, 32'd1);

        // Reset pulsed mid-cycle while a valid result is in W.
        cnt0 = n_results;
        @(negedge clk); drive(32'd11, 32'd13, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); drive(32'd17, 32'd19, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); idle();
        #1;
        chk("pre_reset_valid", {31'b0, W_mul_valid}, 32'd1);
        chk("pre_reset_result", W_mul_result, 32'd143);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", {31'b0, W_mul_valid}, 32'd0);
        chk("async_reset_result", W_mul_result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt0 = n_results;
        repeat (4) @(negedge clk);
        chk("post_reset_none", n_results - cnt0, 32'd0);
        lit("post_reset_fresh", 32'd21, 32'd2, 1'b0, 1'b0, 1'b0, 32'd42);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
